// File: rtl/run_ctrl_if.sv
// run_ctrl_if: host RAM load/dump port of run_ctrl.
// master = host side (req/we/addr/wdata out; gnt/rdata/rvalid in); slave = run_ctrl.
interface run_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rdata, host_rvalid
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rdata, host_rvalid
  );
endinterface

// File: rtl/run_ctrl.sv
// run_ctrl: launches a core run, arbitrates the shared data RAM between
// host (idle/done) and core (run), counts run cycles.
// Ports: clk, rst_n (sync, active low); go; host (run_ctrl_if.slave);
//   core_start/core_halt; core_mem_*; ram_* shared RAM port;
//   busy, done, instr_count, timeout status.
// Optional watchdog: define RUN_CTRL_CYCLE_LIMIT_EN.
module run_ctrl #(
  parameter int          ADDR_W      = 8,
  parameter int          DATA_W      = 8,
  parameter int          CNT_W       = 16,
  parameter int unsigned CYCLE_LIMIT = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  run_ctrl_if.slave         host,
  output logic              core_start,
  input  logic              core_halt,
  input  logic              core_mem_read,
  input  logic              core_mem_write,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_din,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  instr_count,
  output logic              timeout
);

  typedef enum logic [1:0] {
    IDLE, START, RUN, DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              host_slot;
  logic              gnt;
  logic              hrd;
  logic              launch;
  logic              wd_hit;
  logic              core_own;

  assign host_slot = (state_q == IDLE) ||
                     (state_q == DONE);
  // go beats a simultaneous host request
  assign gnt    = rst_n & host.host_req &
                  host_slot & ~go;
  assign hrd    = gnt & ~host.host_we;
  assign launch = host_slot & go;

`ifdef RUN_CTRL_CYCLE_LIMIT_EN
  localparam logic [CNT_W-1:0] LIMIT =
    CNT_W'(CYCLE_LIMIT);

  logic to_q, to_d;

  assign wd_hit = (cnt_q == LIMIT);

  always_comb begin
    to_d = to_q;
    if (launch)
      to_d = 1'b0;
    else if (state_q == RUN && !core_halt && wd_hit)
      to_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) to_q <= 1'b0;
    else        to_q <= to_d;
  end

  assign timeout = to_q;
`else
  logic unused_limit;

  assign unused_limit = ^CYCLE_LIMIT;
  assign wd_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (go) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: state_d = RUN;
      RUN: begin
        if (core_halt)
          state_d = DONE;
        else if (wd_hit)
          state_d = DONE;
        else if (cnt_q != '1)
          cnt_d = cnt_q + 1'b1;
      end
    endcase
  end

  assign rdata_d  = hrd ? ram_dout : rdata_q;
  assign rvalid_d = hrd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign core_own = rst_n & (state_q == RUN);

  always_comb begin
    ram_read  = 1'b0;
    ram_write = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    unique case (1'b1)
      core_own: begin
        ram_read  = core_mem_read;
        ram_write = core_mem_write;
        ram_addr  = core_addr;
        ram_din   = core_din;
      end
      gnt: begin
        ram_read  = ~host.host_we;
        ram_write = host.host_we;
        ram_addr  = host.host_addr;
        ram_din   = host.host_wdata;
      end
      default: ;
    endcase
  end

  assign core_start       = rst_n & (state_q == START);
  assign busy             = (state_q == START) ||
                            (state_q == RUN);
  assign done             = (state_q == DONE);
  assign instr_count      = cnt_q;
  assign host.host_gnt    = gnt;
  assign host.host_rdata  = rdata_q;
  assign host.host_rvalid = rvalid_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed + random stimulus for run_ctrl, checked every
// cycle against a behavioural model of the run/host/RAM rules.
module tb_run_ctrl;

  localparam int CW  = 4;
  localparam int LIM = 10;
  localparam int MAXC = (1 << CW) - 1;
`ifdef RUN_CTRL_CYCLE_LIMIT_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_START = 1;
  localparam int M_RUN   = 2;
  localparam int M_DONE  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          go;
  logic          core_start;
  logic          core_halt;
  logic          core_mem_read;
  logic          core_mem_write;
  logic [7:0]    core_addr;
  logic [7:0]    core_din;
  logic          ram_read;
  logic          ram_write;
  logic [7:0]    ram_addr;
  logic [7:0]    ram_din;
  logic [7:0]    ram_dout;
  logic          busy;
  logic          done;
  logic [CW-1:0] instr_count;
  logic          timeout;

  run_ctrl_if #(.ADDR_W(8), .DATA_W(8)) hif ();

  run_ctrl #(
    .ADDR_W(8), .DATA_W(8), .CNT_W(CW),
    .CYCLE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .go(go),
    .host(hif.slave),
    .core_start(core_start),
    .core_halt(core_halt),
    .core_mem_read(core_mem_read),
    .core_mem_write(core_mem_write),
    .core_addr(core_addr),
    .core_din(core_din),
    .ram_read(ram_read),
    .ram_write(ram_write),
    .ram_addr(ram_addr),
    .ram_din(ram_din),
    .ram_dout(ram_dout),
    .busy(busy), .done(done),
    .instr_count(instr_count),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  // RAM seen by the DUT
  logic [7:0] ram [256];
  always @(posedge clk)
    if (ram_write) ram[ram_addr] <= ram_din;
  assign ram_dout = ram[ram_addr];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // behavioural model
  int         m_st  = M_IDLE;
  int         m_cnt = 0;
  bit         m_to  = 1'b0;
  logic [7:0] m_rd  = 8'h00;
  bit         m_rv  = 1'b0;
  bit         m_ok  = 1'b0;
  logic [7:0] mem [256];

  always @(negedge clk) begin
    bit slot, hg, e_st, e_rr, e_rw;
    logic [7:0] e_ad, e_dn;
    slot = (m_st == M_IDLE) || (m_st == M_DONE);
    hg   = rst_n && hif.host_req && slot && !go;
    e_st = rst_n && (m_st == M_START);
    e_rr = 1'b0; e_rw = 1'b0;
    e_ad = 8'h00; e_dn = 8'h00;
    if (rst_n && m_st == M_RUN) begin
      e_rr = core_mem_read;
      e_rw = core_mem_write;
      e_ad = core_addr;
      e_dn = core_din;
    end else if (hg) begin
      e_rr = !hif.host_we;
      e_rw = hif.host_we;
      e_ad = hif.host_addr;
      e_dn = hif.host_wdata;
    end
    if (m_ok) begin
      chk("gnt", 32'(hif.host_gnt), 32'(hg));
      chk("start", 32'(core_start), 32'(e_st));
      chk("rd", 32'(ram_read), 32'(e_rr));
      chk("wr", 32'(ram_write), 32'(e_rw));
      if (rst_n) begin
        chk("addr", 32'(ram_addr), 32'(e_ad));
        chk("din", 32'(ram_din), 32'(e_dn));
      end
      chk("busy", 32'(busy),
          32'(m_st == M_START || m_st == M_RUN));
      chk("done", 32'(done), 32'(m_st == M_DONE));
      chk("cnt", 32'(instr_count), 32'(m_cnt));
      chk("tmo", 32'(timeout), 32'(m_to));
      chk("rdata", 32'(hif.host_rdata), 32'(m_rd));
      chk("rvalid", 32'(hif.host_rvalid), 32'(m_rv));
    end
    if (!rst_n) begin
      m_st = M_IDLE; m_cnt = 0; m_to = 0;
      m_rd = 8'h00; m_rv = 0; m_ok = 1;
    end else begin
      m_rv = hg && !hif.host_we;
      if (m_rv) m_rd = mem[hif.host_addr];
      if (e_rw) mem[e_ad] = e_dn;
      if (slot) begin
        if (go) begin
          m_st = M_START; m_cnt = 0; m_to = 0;
        end
      end else if (m_st == M_START) begin
        m_st = M_RUN;
      end else if (core_halt) begin
        m_st = M_DONE;
      end else if (WD && m_cnt == LIM) begin
        m_st = M_DONE; m_to = 1;
      end else begin
        m_cnt = (m_cnt < MAXC) ? m_cnt + 1 : MAXC;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'h00;
      mem[i] = 8'h00;
    end
    rst_n = 0; go = 0; core_halt = 0;
    core_mem_read = 0; core_mem_write = 0;
    core_addr = 0; core_din = 0;
    hif.host_req = 0; hif.host_we = 0;
    hif.host_addr = 0; hif.host_wdata = 0;
    step(); step();
    rst_n = 1;
    #1;
    chk("rst_cnt", 32'(instr_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rv", 32'(hif.host_rvalid), 0);

    // host write then read back
    hif.host_req = 1; hif.host_we = 1;
    hif.host_addr = 8'h10; hif.host_wdata = 8'hA5;
    #1;
    chk("hw_gnt", 32'(hif.host_gnt), 1);
    chk("hw_wr", 32'(ram_write), 1);
    chk("hw_addr", 32'(ram_addr), 32'h10);
    step();
    hif.host_we = 0;
    #1;
    chk("hr_gnt", 32'(hif.host_gnt), 1);
    chk("hr_rd", 32'(ram_read), 1);
    step();
    hif.host_req = 0;
    #1;
    chk("hr_rv", 32'(hif.host_rvalid), 1);
    chk("hr_data", 32'(hif.host_rdata), 32'hA5);
    step();
    #1;
    chk("hr_rv0", 32'(hif.host_rvalid), 0);
    chk("hr_hold", 32'(hif.host_rdata), 32'hA5);

    // run with core write, halt after 5 counted cycles
    go = 1;
    step();
    go = 0;
    #1;
    chk("r_start", 32'(core_start), 1);
    chk("r_busy", 32'(busy), 1);
    step();
    core_mem_write = 1;
    core_addr = 8'h20; core_din = 8'h3C;
    #1;
    chk("r_wr", 32'(ram_write), 1);
    chk("r_addr", 32'(ram_addr), 32'h20);
    chk("r_start0", 32'(core_start), 0);
    step();
    core_mem_write = 0;
    repeat (4) step();
    core_halt = 1;
    step();
    core_halt = 0;
    #1;
    chk("r_done", 32'(done), 1);
    chk("r_cnt", 32'(instr_count), 5);
    chk("r_ram", 32'(ram[8'h20]), 32'h3C);

    // go and host_req together in DONE
    go = 1; hif.host_req = 1;
    hif.host_we = 0; hif.host_addr = 8'h10;
    #1;
    chk("c_gnt0", 32'(hif.host_gnt), 0);
    step();
    go = 0;
    #1;
    chk("c_gnt1", 32'(hif.host_gnt), 0);
    chk("c_start", 32'(core_start), 1);
    step();
    #1;
    chk("c_gnt2", 32'(hif.host_gnt), 0);
    repeat (2) step();
    core_halt = 1;
    #1;
    chk("c_gnt3", 32'(hif.host_gnt), 0);
    step();
    core_halt = 0;
    #1;
    chk("c_done", 32'(done), 1);
    chk("c_gnt4", 32'(hif.host_gnt), 1);
    step();
    hif.host_req = 0;
    #1;
    chk("c_rv", 32'(hif.host_rvalid), 1);
    chk("c_rdata", 32'(hif.host_rdata), 32'hA5);
    step();

    // watchdog / saturation: halt stuck low
    go = 1;
    step();
    go = 0;
    step();
    repeat (20) step();
    #1;
    if (WD) begin
      chk("w_done", 32'(done), 1);
      chk("w_tmo", 32'(timeout), 1);
      chk("w_cnt", 32'(instr_count), LIM);
    end else begin
      chk("s_busy", 32'(busy), 1);
      chk("s_tmo", 32'(timeout), 0);
      chk("s_cnt", 32'(instr_count), 32'hF);
    end

    // reset in the middle of a run
    core_halt = 1;
    step();
    core_halt = 0;
    go = 1;
    step();
    go = 0;
    step(); step();
    rst_n = 0; core_mem_write = 1;
    core_addr = 8'h30; core_din = 8'h77;
    #1;
    chk("x_wr0", 32'(ram_write), 0);
    chk("x_st0", 32'(core_start), 0);
    step();
    #1;
    chk("x_wr1", 32'(ram_write), 0);
    step();
    rst_n = 1; core_mem_write = 0;
    #1;
    chk("x_busy", 32'(busy), 0);
    chk("x_done", 32'(done), 0);
    chk("x_cnt", 32'(instr_count), 0);
    chk("x_start", 32'(core_start), 0);
    chk("x_ram", 32'(ram[8'h30]), 0);

    // random traffic
    repeat (3000) begin
      step();
      rst_n          = ($urandom_range(0, 99) != 0);
      go             = ($urandom_range(0, 9) == 0);
      core_halt      = ($urandom_range(0, 4) == 0);
      core_mem_read  = 1'($urandom);
      core_mem_write = 1'($urandom);
      core_addr      = 8'($urandom_range(0, 15));
      core_din       = 8'($urandom);
      hif.host_req   = 1'($urandom);
      hif.host_we    = 1'($urandom);
      hif.host_addr  = 8'($urandom_range(0, 15));
      hif.host_wdata = 8'($urandom);
    end
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
